pwm_config_sequencer: RTL and testbench
=======================================

Name: pwm_config_sequencer

Overview:
Run-time configuration controller in front of the multi-phase PWM generator top level. It accepts configuration writes through a valid/ready handshake and validates them in shadow registers. Compare, step and dead-time changes commit on a carrier boundary. A PWMMaxCount change forces a gated reset/restart sequence, because max count must not change without resetting the core.

Parameters:
PhaseCount, 3, number of phases / compare words
BIT_WIDTH, 16, width of every count/compare word
RESET_HOLD_CYCLES, 4, cycles the PWM core is held in reset on start/restart (>=1)
WATCHDOG_CYCLES, 65535, sync-wait limit; used only with the optional feature

Ports:
MClk  in  1  clock
RstN  in  1  asynchronous active-low reset
Enable  in  1  run request (level)
CfgValid  in  1  config write valid
CfgReady  out  1  config write ready
CfgCompare  in  PhaseCount*BIT_WIDTH  compare words, phase i at [i*BIT_WIDTH +: BIT_WIDTH]
CfgMaxCount  in  BIT_WIDTH  requested carrier max count
CfgStepSize  in  BIT_WIDTH  requested triangle step
CfgDeadTime  in  BIT_WIDTH  requested dead-time count
PeriodSync  in  1  one-cycle carrier-zero pulse from PWM core
Compare  out  PhaseCount*BIT_WIDTH  active compare words to core
PWMMaxCount  out  BIT_WIDTH  active max count
TriangleStepSize  out  BIT_WIDTH  active step
DeadTimeCount  out  BIT_WIDTH  active dead time
CoreRstN  out  1  active-low reset to PWM core
OutEnable  out  1  gate for switch outputs S
Busy  out  1  high in START, PEND, REINIT
CfgError  out  1  sticky: last accepted write invalid
SyncTimeout  out  1  sticky watchdog flag

Behaviour:
- Reset (RstN low, async): state IDLE. All active and shadow registers are 0, ShadowValid=0, CoreRstN=0, OutEnable=0, CfgError=0, SyncTimeout=0, CfgReady=0. All outputs are registered.
- Handshake: a transfer occurs when CfgValid&&CfgReady at a rising edge. CfgReady=1 only in IDLE and RUN. CfgValid may be held with stable data.
- Validation on transfer, all combinational on Cfg* inputs:
  - Invalid if MaxCount==0, StepSize==0, StepSize>MaxCount, any compare word>MaxCount, or DeadTime>=MaxCount.
  - Invalid write: not stored, CfgError<=1, state unchanged.
  - Valid write: stored in shadow, ShadowValid<=1, CfgError<=0.
- IDLE: if Enable && ShadowValid (evaluated on registered ShadowValid, so at earliest the cycle after the accepting edge): active<=shadow, hold counter<=RESET_HOLD_CYCLES, go to START.
- START: CoreRstN=0 and OutEnable=0. Counter decrements each cycle. On the cycle it reads 1: CoreRstN<=1, OutEnable<=1, go to RUN. With START entered at edge T, CoreRstN and OutEnable rise at edge T+RESET_HOLD_CYCLES.
- RUN, valid write accepted:
  - MaxCount==active max: go to PEND.
  - Otherwise: go to REINIT.
  - Invalid write: stays in RUN.
- PEND: on PeriodSync, Compare/TriangleStepSize/DeadTimeCount<=shadow (visible the cycle after the pulse), go to RUN. Max count is untouched.
- REINIT: on PeriodSync, OutEnable<=0, CoreRstN<=0, all active<=shadow, counter reload, go to START.
- Enable low in START/RUN/PEND/REINIT: next edge OutEnable<=0, CoreRstN<=0, go to IDLE. Shadow and ShadowValid are kept, so re-enable restarts with the latest shadow.
- Simultaneous events:
  - Enable-low beats PeriodSync.
  - PeriodSync in RUN is ignored.
  - Enable low during a transfer: the write is still stored.
- PeriodSync is only meaningful while CoreRstN=1. Pulses during START are ignored.

Optional Feature:
PWM_SYNC_WATCHDOG_EN
- Defined:
  - A counter runs in PEND/REINIT and clears on entry and on PeriodSync.
  - On reaching WATCHDOG_CYCLES, SyncTimeout<=1 (sticky until reset) and the block takes the REINIT commit path immediately from either state: outputs gated, full reload, START.
- Undefined: no counter. SyncTimeout is tied 0, and PEND/REINIT wait indefinitely.

Decomposition:
- Package pwm_seq_pkg holds:
  - state enum (IDLE, START, PEND, REINIT, RUN)
  - a config struct type (compare array, max, step, dead)
  - hold-counter width constant, $clog2(RESET_HOLD_CYCLES+1)
- One sub-module: pwm_cfg_validator, purely combinational, Cfg* -> cfg_ok.

Test Plan:
- Write {max=1000, step=10, dead=20, cmp=500/250/750} in IDLE, then Enable=1 -> START entered 1 cycle later. CoreRstN and OutEnable rise exactly 4 cycles after START entry, and outputs show the written values.
- In RUN, write cmp=600/300/900 with same max -> CfgReady=0, Busy=1. Outputs unchanged until PeriodSync, then updated the next cycle, and CoreRstN stays 1 throughout.
- In RUN, write max=2000 -> REINIT. On PeriodSync, OutEnable=0 and CoreRstN=0 the next cycle, PWMMaxCount=2000, then re-release after 4 cycles.
- Write max=0, then write step=1200 with max=1000 -> neither stored, CfgError=1, outputs unchanged. A following valid write clears CfgError.
- In PEND, drop Enable in the same cycle as PeriodSync -> IDLE, OutEnable=0, no commit. Re-enable -> START loads the pending shadow.
- PWM_SYNC_WATCHDOG_EN with WATCHDOG_CYCLES=100, PEND and no PeriodSync -> at cycle 100 SyncTimeout=1, forced START, new config active. Without the macro, SyncTimeout stays 0.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM configuration sequencer.
// Optional build macro used by the top: PWM_SYNC_WATCHDOG_EN.
package pwm_seq_pkg;

  localparam int unsigned PhaseCountDef = 3;
  localparam int unsigned BitWidthDef   = 16;
  localparam int unsigned ResetHoldDef  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPend,
    StReinit,
    StRun
  } seq_state_e;

  typedef struct packed {
    logic [PhaseCountDef-1:0][BitWidthDef-1:0] cmp;
    logic [BitWidthDef-1:0]                    max;
    logic [BitWidthDef-1:0]                    step;
    logic [BitWidthDef-1:0]                    dead;
  } pwm_cfg_t;

  function automatic int unsigned hold_cnt_w(input int unsigned hold);
    return $clog2(hold + 1);
  endfunction

  localparam int unsigned HoldCntW = $clog2(ResetHoldDef + 1);

endpackage

// File: rtl/pwm_cfg_validator.sv
// Combinational legality check of a requested PWM configuration.
module pwm_cfg_validator
  import pwm_seq_pkg::*;
#(
  parameter int unsigned PhaseCount = PhaseCountDef,
  parameter int unsigned BIT_WIDTH  = BitWidthDef
) (
  input  logic [PhaseCount*BIT_WIDTH-1:0] i_compare,
  input  logic [BIT_WIDTH-1:0]            i_max_count,
  input  logic [BIT_WIDTH-1:0]            i_step_size,
  input  logic [BIT_WIDTH-1:0]            i_dead_time,
  output logic                            o_cfg_ok
);

  logic w_ok;

  always_comb begin
    w_ok = (i_max_count != '0) && (i_step_size != '0) &&
           (i_step_size <= i_max_count) && (i_dead_time < i_max_count);
    for (int i = 0; i < PhaseCount; i++) begin
      if (i_compare[i*BIT_WIDTH +: BIT_WIDTH] > i_max_count) begin
        w_ok = 1'b0;
      end
    end
  end

  assign o_cfg_ok = w_ok;

endmodule

// File: rtl/pwm_config_sequencer.sv
// Run-time configuration sequencer for the multi-phase PWM core: shadow/commit and restart control.
// Optional sync watchdog enabled by defining PWM_SYNC_WATCHDOG_EN.
module pwm_config_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned PhaseCount        = PhaseCountDef,
  parameter int unsigned BIT_WIDTH         = BitWidthDef,
  parameter int unsigned RESET_HOLD_CYCLES = ResetHoldDef,
  parameter int unsigned WATCHDOG_CYCLES   = 65535
) (
  input  logic                            MClk,
  input  logic                            RstN,
  input  logic                            Enable,
  input  logic                            CfgValid,
  output logic                            CfgReady,
  input  logic [PhaseCount*BIT_WIDTH-1:0] CfgCompare,
  input  logic [BIT_WIDTH-1:0]            CfgMaxCount,
  input  logic [BIT_WIDTH-1:0]            CfgStepSize,
  input  logic [BIT_WIDTH-1:0]            CfgDeadTime,
  input  logic                            PeriodSync,
  output logic [PhaseCount*BIT_WIDTH-1:0] Compare,
  output logic [BIT_WIDTH-1:0]            PWMMaxCount,
  output logic [BIT_WIDTH-1:0]            TriangleStepSize,
  output logic [BIT_WIDTH-1:0]            DeadTimeCount,
  output logic                            CoreRstN,
  output logic                            OutEnable,
  output logic                            Busy,
  output logic                            CfgError,
  output logic                            SyncTimeout
);

  localparam int unsigned HoldW = hold_cnt_w(RESET_HOLD_CYCLES);

  seq_state_e       r_state, w_state_d;
  logic [HoldW-1:0] r_hold, w_hold_d;
  pwm_cfg_t         r_active, w_active_d;
  pwm_cfg_t         r_shadow, w_shadow_d;
  logic             r_shadow_valid, w_shadow_valid_d;
  logic             r_cfg_error, w_cfg_error_d;
  logic             r_core_rst_n, w_core_rst_n_d;
  logic             r_out_en, w_out_en_d;
  logic             r_busy, w_busy_d;
  logic             r_cfg_ready, w_cfg_ready_d;
  logic             w_sync_timeout_d;
  logic             w_wd_hit;

  pwm_cfg_t w_cfg;
  logic     w_cfg_ok;
  logic     w_xfer;

  always_comb begin
    w_cfg      = '0;
    w_cfg.cmp  = CfgCompare;
    w_cfg.max  = CfgMaxCount;
    w_cfg.step = CfgStepSize;
    w_cfg.dead = CfgDeadTime;
  end

  assign w_xfer = CfgValid && r_cfg_ready;

  pwm_cfg_validator #(
    .PhaseCount (PhaseCount),
    .BIT_WIDTH  (BIT_WIDTH)
  ) u_validator (
    .i_compare   (CfgCompare),
    .i_max_count (CfgMaxCount),
    .i_step_size (CfgStepSize),
    .i_dead_time (CfgDeadTime),
    .o_cfg_ok    (w_cfg_ok)
  );

`ifdef PWM_SYNC_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WdogW-1:0] r_wdog, w_wdog_d;
  logic             r_sync_timeout;
  logic             w_waiting;

  // Counter restarts whenever the waiting state is (re)entered or a sync arrives.
  assign w_waiting = (r_state == StPend) || (r_state == StReinit);
  assign w_wd_hit  = w_waiting && !PeriodSync &&
                     ((r_wdog + WdogW'(1)) == WdogW'(WATCHDOG_CYCLES));
  assign w_wdog_d  = (w_waiting && (w_state_d == r_state) && !PeriodSync) ?
                     r_wdog + WdogW'(1) : '0;

  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      r_wdog         <= '0;
      r_sync_timeout <= 1'b0;
    end else begin
      r_wdog         <= w_wdog_d;
      r_sync_timeout <= w_sync_timeout_d;
    end
  end

  assign SyncTimeout = r_sync_timeout;
`else
  logic w_unused_wdog;

  assign w_wd_hit      = 1'b0;
  assign w_unused_wdog = ^WATCHDOG_CYCLES ^ w_sync_timeout_d;
  assign SyncTimeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      r_state        <= StIdle;
      r_hold         <= '0;
      r_active       <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_cfg_error    <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_out_en       <= 1'b0;
      r_busy         <= 1'b0;
      r_cfg_ready    <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_hold         <= w_hold_d;
      r_active       <= w_active_d;
      r_shadow       <= w_shadow_d;
      r_shadow_valid <= w_shadow_valid_d;
      r_cfg_error    <= w_cfg_error_d;
      r_core_rst_n   <= w_core_rst_n_d;
      r_out_en       <= w_out_en_d;
      r_busy         <= w_busy_d;
      r_cfg_ready    <= w_cfg_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d        = r_state;
    w_hold_d         = r_hold;
    w_active_d       = r_active;
    w_shadow_d       = r_shadow;
    w_shadow_valid_d = r_shadow_valid;
    w_cfg_error_d    = r_cfg_error;
    w_sync_timeout_d = SyncTimeout;

    // Shadow capture is independent of the state move, so a write is kept even on disable.
    if (w_xfer) begin
      if (w_cfg_ok) begin
        w_shadow_d       = w_cfg;
        w_shadow_valid_d = 1'b1;
        w_cfg_error_d    = 1'b0;
      end else begin
        w_cfg_error_d = 1'b1;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (Enable && r_shadow_valid) begin
          w_active_d = r_shadow;
          w_hold_d   = HoldW'(RESET_HOLD_CYCLES);
          w_state_d  = StStart;
        end
      end
      StStart: begin
        if (!Enable) begin
          w_state_d = StIdle;
        end else if (r_hold == HoldW'(1)) begin
          w_state_d = StRun;
        end else begin
          w_hold_d = r_hold - HoldW'(1);
        end
      end
      StRun: begin
        if (!Enable) begin
          w_state_d = StIdle;
        end else if (w_xfer && w_cfg_ok) begin
          w_state_d = (CfgMaxCount == r_active.max) ? StPend : StReinit;
        end
      end
      StPend: begin
        if (!Enable) begin
          w_state_d = StIdle;
        end else if (PeriodSync) begin
          w_active_d.cmp  = r_shadow.cmp;
          w_active_d.step = r_shadow.step;
          w_active_d.dead = r_shadow.dead;
          w_state_d       = StRun;
        end else if (w_wd_hit) begin
          w_sync_timeout_d = 1'b1;
          w_active_d       = r_shadow;
          w_hold_d         = HoldW'(RESET_HOLD_CYCLES);
          w_state_d        = StStart;
        end
      end
      StReinit: begin
        if (!Enable) begin
          w_state_d = StIdle;
        end else if (PeriodSync || w_wd_hit) begin
          w_sync_timeout_d = SyncTimeout | w_wd_hit;
          w_active_d       = r_shadow;
          w_hold_d         = HoldW'(RESET_HOLD_CYCLES);
          w_state_d        = StStart;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: registered outputs follow the state being entered.
  always_comb begin
    w_core_rst_n_d = 1'b0;
    w_out_en_d     = 1'b0;
    w_busy_d       = 1'b0;
    w_cfg_ready_d  = 1'b0;
    unique case (w_state_d)
      StIdle: w_cfg_ready_d = 1'b1;
      StStart: w_busy_d = 1'b1;
      StRun: begin
        w_core_rst_n_d = 1'b1;
        w_out_en_d     = 1'b1;
        w_cfg_ready_d  = 1'b1;
      end
      StPend, StReinit: begin
        w_core_rst_n_d = 1'b1;
        w_out_en_d     = 1'b1;
        w_busy_d       = 1'b1;
      end
      default: ;
    endcase
  end

  assign Compare          = r_active.cmp;
  assign PWMMaxCount      = r_active.max;
  assign TriangleStepSize = r_active.step;
  assign DeadTimeCount    = r_active.dead;
  assign CoreRstN         = r_core_rst_n;
  assign OutEnable        = r_out_en;
  assign Busy             = r_busy;
  assign CfgReady         = r_cfg_ready;
  assign CfgError         = r_cfg_error;

endmodule

// File: tb/tb_pwm_config_sequencer.sv
// Directed self-checking bench for pwm_config_sequencer (watchdog section follows PWM_SYNC_WATCHDOG_EN).
module tb_pwm_config_sequencer;

  localparam int unsigned Pc = 3;
  localparam int unsigned Bw = 16;

  logic           MClk;
  logic           RstN;
  logic           Enable;
  logic           CfgValid;
  logic           CfgReady;
  logic [Pc*Bw-1:0] CfgCompare;
  logic [Bw-1:0]  CfgMaxCount;
  logic [Bw-1:0]  CfgStepSize;
  logic [Bw-1:0]  CfgDeadTime;
  logic           PeriodSync;
  logic [Pc*Bw-1:0] Compare;
  logic [Bw-1:0]  PWMMaxCount;
  logic [Bw-1:0]  TriangleStepSize;
  logic [Bw-1:0]  DeadTimeCount;
  logic           CoreRstN;
  logic           OutEnable;
  logic           Busy;
  logic           CfgError;
  logic           SyncTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_config_sequencer #(
    .PhaseCount        (Pc),
    .BIT_WIDTH         (Bw),
    .RESET_HOLD_CYCLES (4),
    .WATCHDOG_CYCLES   (100)
  ) dut (
    .MClk             (MClk),
    .RstN             (RstN),
    .Enable           (Enable),
    .CfgValid         (CfgValid),
    .CfgReady         (CfgReady),
    .CfgCompare       (CfgCompare),
    .CfgMaxCount      (CfgMaxCount),
    .CfgStepSize      (CfgStepSize),
    .CfgDeadTime      (CfgDeadTime),
    .PeriodSync       (PeriodSync),
    .Compare          (Compare),
    .PWMMaxCount      (PWMMaxCount),
    .TriangleStepSize (TriangleStepSize),
    .DeadTimeCount    (DeadTimeCount),
    .CoreRstN         (CoreRstN),
    .OutEnable        (OutEnable),
    .Busy             (Busy),
    .CfgError         (CfgError),
    .SyncTimeout      (SyncTimeout)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MClk);
    #1;
  endtask

  task automatic wr(input int c0, input int c1, input int c2, input int mx, input int st,
                    input int dt);
    CfgValid    = 1'b1;
    CfgCompare  = {c2[15:0], c1[15:0], c0[15:0]};
    CfgMaxCount = mx[15:0];
    CfgStepSize = st[15:0];
    CfgDeadTime = dt[15:0];
    tick();
    CfgValid = 1'b0;
  endtask

  initial begin
    RstN        = 1'b0;
    Enable      = 1'b0;
    CfgValid    = 1'b0;
    CfgCompare  = '0;
    CfgMaxCount = '0;
    CfgStepSize = '0;
    CfgDeadTime = '0;
    PeriodSync  = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_corerstn", CoreRstN, 0);
    check("rst_outen", OutEnable, 0);
    check("rst_ready", CfgReady, 0);
    check("rst_busy", Busy, 0);
    check("rst_err", CfgError, 0);
    check("rst_timeout", SyncTimeout, 0);
    check("rst_max", PWMMaxCount, 0);
    check("rst_cmp", Compare, 0);
    RstN = 1'b1;
    tick();
    check("idle_ready", CfgReady, 1);

    // Initial write in IDLE with Enable: START one cycle after the accepting edge
    Enable = 1'b1;
    wr(500, 250, 750, 1000, 10, 20);
    check("idle_after_wr_busy", Busy, 0);
    tick();
    check("start_busy", Busy, 1);
    check("start_ready", CfgReady, 0);
    check("start_max", PWMMaxCount, 1000);
    check("start_cmp", Compare, {16'd750, 16'd250, 16'd500});
    check("start_step", TriangleStepSize, 10);
    check("start_dead", DeadTimeCount, 20);
    repeat (3) tick();
    check("start_hold_rst", CoreRstN, 0);
    check("start_hold_oe", OutEnable, 0);
    tick();
    check("run_corerstn", CoreRstN, 1);
    check("run_outen", OutEnable, 1);
    check("run_busy", Busy, 0);

    // Same-max write goes to PEND and commits on PeriodSync
    wr(600, 300, 900, 1000, 10, 20);
    check("pend_ready", CfgReady, 0);
    check("pend_busy", Busy, 1);
    tick();
    tick();
    check("pend_cmp_held", Compare, {16'd750, 16'd250, 16'd500});
    check("pend_core_up", CoreRstN, 1);
    PeriodSync = 1'b1;
    tick();
    PeriodSync = 1'b0;
    check("pend_commit_cmp", Compare, {16'd900, 16'd300, 16'd600});
    check("pend_commit_busy", Busy, 0);
    check("pend_commit_core", CoreRstN, 1);

    // Max change goes through REINIT and a full restart
    wr(600, 300, 900, 2000, 10, 20);
    check("reinit_busy", Busy, 1);
    check("reinit_max_held", PWMMaxCount, 1000);
    check("reinit_oe_held", OutEnable, 1);
    PeriodSync = 1'b1;
    tick();
    PeriodSync = 1'b0;
    check("reinit_oe_drop", OutEnable, 0);
    check("reinit_core_drop", CoreRstN, 0);
    check("reinit_max", PWMMaxCount, 2000);
    PeriodSync = 1'b1;  // ignored during START
    tick();
    PeriodSync = 1'b0;
    tick();
    tick();
    check("reinit_hold_rst", CoreRstN, 0);
    tick();
    check("reinit_release", CoreRstN, 1);
    check("reinit_release_oe", OutEnable, 1);

    // Invalid writes are rejected and flag CfgError
    wr(500, 500, 500, 0, 10, 20);
    check("inv_max0_err", CfgError, 1);
    check("inv_max0_ready", CfgReady, 1);
    wr(500, 500, 500, 1000, 1200, 20);
    check("inv_step_err", CfgError, 1);
    check("inv_step_max", PWMMaxCount, 2000);
    wr(100, 100, 100, 2000, 10, 2000);
    check("inv_dead_err", CfgError, 1);
    check("inv_dead_busy", Busy, 0);
    wr(100, 2001, 100, 2000, 10, 20);
    check("inv_cmp_err", CfgError, 1);
    wr(100, 200, 300, 2000, 5, 30);
    check("valid_clears_err", CfgError, 0);
    check("valid_pend_busy", Busy, 1);

    // Enable drop beats PeriodSync in PEND; re-enable loads pending shadow
    Enable     = 1'b0;
    PeriodSync = 1'b1;
    tick();
    PeriodSync = 1'b0;
    check("dis_oe", OutEnable, 0);
    check("dis_core", CoreRstN, 0);
    check("dis_busy", Busy, 0);
    check("dis_no_commit", Compare, {16'd900, 16'd300, 16'd600});
    Enable = 1'b1;
    tick();
    check("reen_busy", Busy, 1);
    check("reen_cmp", Compare, {16'd300, 16'd200, 16'd100});
    check("reen_step", TriangleStepSize, 5);
    check("reen_dead", DeadTimeCount, 30);
    repeat (4) tick();
    check("reen_run", CoreRstN, 1);

    // Boundary values are legal: step==max, cmp==max, dead==max-1
    wr(2000, 0, 1999, 2000, 2000, 1999);
    check("bnd_err", CfgError, 0);
    check("bnd_pend", Busy, 1);

`ifdef PWM_SYNC_WATCHDOG_EN
    repeat (99) tick();
    check("wd_before", SyncTimeout, 0);
    check("wd_before_core", CoreRstN, 1);
    tick();
    check("wd_timeout", SyncTimeout, 1);
    check("wd_core_drop", CoreRstN, 0);
    check("wd_cmp", Compare, {16'd1999, 16'd0, 16'd2000});
    check("wd_step", TriangleStepSize, 2000);
    repeat (4) tick();
    check("wd_release", CoreRstN, 1);
    check("wd_sticky", SyncTimeout, 1);
`else
    repeat (120) tick();
    check("nowd_timeout", SyncTimeout, 0);
    check("nowd_busy", Busy, 1);
    check("nowd_cmp_held", Compare, {16'd300, 16'd200, 16'd100});
    PeriodSync = 1'b1;
    tick();
    PeriodSync = 1'b0;
    check("nowd_commit_cmp", Compare, {16'd1999, 16'd0, 16'd2000});
    check("nowd_commit_dead", DeadTimeCount, 1999);
    check("nowd_commit_busy", Busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
